// File: rtl/reg_wb_ctrl_pkg.sv
// reg_wb_pkg: shared widths and the writeback request type for the register-file write controller
package reg_wb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// reg_wb_ctrl_if: ALU/memory writeback requests, pending marks and register-file write port
interface reg_wb_ctrl_if
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic                         alu_valid;
  logic [REG_AW-1:0]            alu_addr;
  logic [DATA_W-1:0]            alu_data;
  logic                         alu_ack;
  logic                         alu_stall;
  logic                         mem_valid;
  logic                         mem_ready;
  logic [REG_AW-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_data;
  logic                         pend_set;
  logic [REG_AW-1:0]            pend_addr;
  logic [REG_AW-1:0]            wAddr;
  logic [DATA_W-1:0]            wDin;
  logic                         wEna;
  logic [NUM_REGS-1:0]          busy_mask;
  logic [$clog2(DEPTH+1)-1:0]   fifo_cnt;
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, pend_set, pend_addr,
    input  alu_ack, alu_stall, mem_ready, wAddr, wDin, wEna, busy_mask, fifo_cnt
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, pend_set, pend_addr,
    output alu_ack, alu_stall, mem_ready, wAddr, wDin, wEna, busy_mask, fifo_cnt
  );
endinterface

// File: rtl/reg_wb_ctrl_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests; pointers wrap naturally, count kept separately
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  wb_req_t                    din_i,
  input  logic                       pop_i,
  output wb_req_t                    dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_req_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  // storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: merges ALU and buffered memory-path writebacks onto the single register-file write port
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst_n,
  reg_wb_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX+1);
  wb_req_t head, win, push_req;
  logic empty, full, pop, win_v;
  logic [SW-1:0] starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, set_m, clr_m;
  logic [REG_AW-1:0] w_addr_q;
  logic [DATA_W-1:0] w_din_q;
  logic w_ena_q;
  assign push_req = {bus.mem_addr, bus.mem_data};
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(bus.mem_valid),
    .din_i(push_req),
    .pop_i(pop),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(bus.fifo_cnt)
  );
  assign bus.alu_stall = starve_q == SW'(STARVE_MAX);
  assign bus.alu_ack = bus.alu_valid & ~bus.alu_stall;
  assign bus.mem_ready = ~full;
  assign bus.wAddr = w_addr_q;
  assign bus.wDin = w_din_q;
  assign bus.wEna = w_ena_q;
  assign bus.busy_mask = busy_q;
  // a stall only arises with a non-empty FIFO, so the pop never underflows
  always_comb begin
    pop = ~empty & (bus.alu_stall | ~bus.alu_valid);
    win = pop ? head : {bus.alu_addr, bus.alu_data};
    win_v = pop | bus.alu_ack;
    starve_d = (empty | pop) ? '0 : starve_q + 1'b1;
    set_m = (bus.pend_set && bus.pend_addr != '0) ? NUM_REGS'(1) << bus.pend_addr : '0;
    clr_m = (pop && head.addr != '0) ? NUM_REGS'(1) << head.addr : '0;
    busy_d = (busy_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      busy_q <= '0;
      w_ena_q <= 1'b0;
      w_addr_q <= '0;
      w_din_q <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q <= busy_d;
      w_ena_q <= win_v && win.addr != '0;
      if (win_v) begin
        w_addr_q <= win.addr;
        w_din_q <= win.data;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed stimulus with a write scoreboard checked by an independent monitor
module tb_reg_wb_ctrl;
  import reg_wb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_req_t exp_q[$];
  wb_req_t mon_e;
  reg_wb_ctrl_if #(.DEPTH(4)) bus();
  reg_wb_ctrl #(.DEPTH(4), .STARVE_MAX(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // every write-port pulse must match the next expected write in order
  always @(negedge clk) begin
    if (rst_n && bus.wEna === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.wAddr, bus.wDin);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {27'b0, bus.wAddr}, {27'b0, mon_e.addr});
        chk("wr_data", bus.wDin, mon_e.data);
      end
    end
  end

  task automatic drv(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic ps, input logic [4:0] pa);
    bus.alu_valid = av;
    bus.alu_addr = aa;
    bus.alu_data = ad;
    bus.mem_valid = mv;
    bus.mem_addr = ma;
    bus.mem_data = md;
    bus.pend_set = ps;
    bus.pend_addr = pa;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  initial begin
    idle();
    #2;
    chk("rst_wena", {31'b0, bus.wEna}, 0);
    chk("rst_waddr", {27'b0, bus.wAddr}, 0);
    chk("rst_wdin", bus.wDin, 0);
    chk("rst_cnt", {29'b0, bus.fifo_cnt}, 0);
    chk("rst_busy", bus.busy_mask, 0);
    chk("rst_ready", {31'b0, bus.mem_ready}, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // single ALU write, then hold on idle
    drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expw(5, 32'hDEADBEEF);
    #1 chk("alu_ack", {31'b0, bus.alu_ack}, 1);
    step();
    idle();
    step();
    chk("idle_wena", {31'b0, bus.wEna}, 0);
    chk("hold_waddr", {27'b0, bus.wAddr}, 5);
    chk("hold_wdin", bus.wDin, 32'hDEADBEEF);
    // writes and pending marks to register 0 are dropped
    drv(1, 0, 32'h1234, 0, 0, 0, 1, 0);
    #1 chk("r0_ack", {31'b0, bus.alu_ack}, 1);
    step();
    idle();
    chk("r0_wena", {31'b0, bus.wEna}, 0);
    chk("r0_busy", bus.busy_mask, 0);
    // fill the FIFO while the ALU keeps winning
    for (int k = 0; k < 4; k++) begin
      drv(1, 9, 32'h900 + k, 1, 5'(k + 1), 32'h10 * (k + 1), 0, 0);
      expw(9, 32'h900 + k);
      #1;
      chk("fill_ready", {31'b0, bus.mem_ready}, 1);
      chk("fill_ack", {31'b0, bus.alu_ack}, 1);
      chk("fill_stall", {31'b0, bus.alu_stall}, 0);
      step();
    end
    chk("full_cnt", {29'b0, bus.fifo_cnt}, 4);
    chk("full_ready", {31'b0, bus.mem_ready}, 0);
    drv(1, 9, 32'h904, 1, 31, 32'hBAD, 0, 0);
    expw(1, 32'h10);
    #1;
    chk("starve_stall", {31'b0, bus.alu_stall}, 1);
    chk("starve_ack", {31'b0, bus.alu_ack}, 0);
    step();
    drv(1, 9, 32'h904, 0, 0, 0, 0, 0);
    expw(9, 32'h904);
    #1 chk("resume_ack", {31'b0, bus.alu_ack}, 1);
    step();
    chk("after_pop_cnt", {29'b0, bus.fifo_cnt}, 3);
    idle();
    expw(2, 32'h20);
    expw(3, 32'h30);
    expw(4, 32'h40);
    repeat (3) step();
    chk("drain_cnt", {29'b0, bus.fifo_cnt}, 0);
    // pending scoreboard
    drv(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    idle();
    chk("pend7", bus.busy_mask, 32'h80);
    drv(0, 0, 0, 1, 7, 32'hAA, 0, 0);
    expw(7, 32'hAA);
    step();
    idle();
    step();
    chk("clr7_busy", bus.busy_mask, 0);
    chk("clr7_wena", {31'b0, bus.wEna}, 1);
    drv(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    chk("pend7_again", bus.busy_mask, 32'h80);
    drv(0, 0, 0, 1, 7, 32'hBB, 0, 0);
    expw(7, 32'hBB);
    step();
    drv(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    idle();
    chk("set_wins", bus.busy_mask, 32'h80);
    drv(0, 0, 0, 1, 7, 32'hCC, 0, 0);
    expw(7, 32'hCC);
    step();
    idle();
    step();
    chk("clr7_final", bus.busy_mask, 0);
    // a push into an empty FIFO cannot pop in the same cycle
    drv(0, 0, 0, 1, 14, 32'hE0, 0, 0);
    expw(14, 32'hE0);
    step();
    idle();
    chk("empty_push_cnt", {29'b0, bus.fifo_cnt}, 1);
    chk("empty_push_wena", {31'b0, bus.wEna}, 0);
    step();
    chk("empty_pop_cnt", {29'b0, bus.fifo_cnt}, 0);
    // simultaneous push and pop
    drv(1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0);
    expw(10, 32'hA0);
    step();
    drv(1, 10, 32'hA1, 1, 12, 32'hC0, 0, 0);
    expw(10, 32'hA1);
    step();
    chk("two_cnt", {29'b0, bus.fifo_cnt}, 2);
    drv(0, 0, 0, 1, 13, 32'hD0, 0, 0);
    expw(11, 32'hB0);
    step();
    chk("pushpop_cnt", {29'b0, bus.fifo_cnt}, 2);
    idle();
    expw(12, 32'hC0);
    expw(13, 32'hD0);
    repeat (2) step();
    chk("pushpop_drain", {29'b0, bus.fifo_cnt}, 0);
    // reset mid-operation drops queued writes and pending marks
    drv(1, 20, 32'h200, 1, 1, 32'h1, 1, 1);
    expw(20, 32'h200);
    step();
    drv(1, 20, 32'h201, 1, 2, 32'h2, 1, 2);
    expw(20, 32'h201);
    step();
    drv(1, 20, 32'h202, 1, 3, 32'h3, 1, 3);
    expw(20, 32'h202);
    step();
    idle();
    chk("pre_rst_busy", bus.busy_mask, 32'h0E);
    chk("pre_rst_cnt", {29'b0, bus.fifo_cnt}, 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wena", {31'b0, bus.wEna}, 0);
    chk("arst_cnt", {29'b0, bus.fifo_cnt}, 0);
    chk("arst_busy", bus.busy_mask, 0);
    chk("arst_ready", {31'b0, bus.mem_ready}, 1);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_wena", {31'b0, bus.wEna}, 0);
    end
    chk("post_rst_cnt", {29'b0, bus.fifo_cnt}, 0);
    @(negedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
